wb_copy_master: RTL
===================

Name: wb_copy_master

Overview:
- Wishbone classic initiator (bus master) that copies a block of 16-bit words from one bus address range to another: read a word, write it, repeat.
- Sits beside the Processor on the shared 24-bit-address / 16-bit-data bus. It is used to load program memory (0x01xxxx) and the register memory (0x00xxxx) from a source region, or to move data between them, without processor involvement.

Parameters:
- ADDR_W, 24, Wishbone address width.
- DATA_W, 16, Wishbone data width.
- LEN_W, 16, width of the word-count fields.
- TIMEOUT, 255, maximum cycles a strobe waits for wbAckI before the transfer aborts (must be ≥ 1).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- srcAdr  in  ADDR_W  first source word address; latched on accepted start.
- dstAdr  in  ADDR_W  first destination word address; latched on accepted start.
- len  in  LEN_W  number of words to copy; latched on accepted start.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle completion pulse (success or error).
- error  out  1  sticky timeout flag; cleared on the next accepted start.
- wordsDone  out  LEN_W  count of words fully written in the current/last job.
- wbAdrO  out  ADDR_W  bus address.
- wbDatO  out  DATA_W  write data.
- wbDatI  in  DATA_W  read data.
- wbCycO  out  1  bus cycle.
- wbStbO  out  1  strobe.
- wbWeO  out  1  write enable.
- wbAckI  in  1  slave acknowledge.

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Applies mid-job: the bus is released (cyc/stb/we = 0) at that edge and no done pulse is issued.
- States: IDLE, RD, RGAP, WR, WGAP, FIN.
- IDLE:
  - start=1 latches srcAdr, dstAdr, len; clears error and wordsDone; sets busy.
  - len≠0 → RD.
  - len=0 → FIN. No bus activity.
- RD:
  - Outputs: cyc=1, stb=1, we=0, adr = src+i, where i is the word index.
  - On a clock where wbAckI=1: capture wbDatI into the data register, → RGAP.
- RGAP:
  - Outputs: stb=0, cyc=1. wbAckI is ignored.
  - Exactly one cycle, then → WR.
  - The gap is mandatory: slaves with a registered wait state keep ack high for one cycle after stb drops.
- WR:
  - Outputs: cyc=1, stb=1, we=1, adr = dst+i, wbDatO = captured data.
  - On ack: wordsDone+1, i+1, → WGAP.
- WGAP:
  - Outputs: stb=0, cyc=1, we=0. One cycle.
  - If i == len → FIN, else → RD.
- FIN:
  - Outputs: cyc=0, stb=0, done=1 for one cycle, busy=0 on the same edge. → IDLE.
- wbAckI is acted on only in RD/WR (stb high). Ack seen in any other state is ignored.
- Timeout:
  - A per-strobe counter resets on entry to RD/WR and increments each cycle without ack.
  - Reaching TIMEOUT → error=1, bus released, → FIN. wordsDone keeps the count reached.
- Address arithmetic is modulo 2^ADDR_W: 0xFFFFFF+1 wraps to 0x000000, with no error.
- wbDatO holds its last value outside WR. wbAdrO and wbWeO are 0 in IDLE/FIN.
- start while busy is ignored. start in the same cycle as the FIN done pulse is also ignored; it is accepted only in IDLE.
- Throughput with zero-wait slaves (ack one cycle after stb): 4 clocks per word, plus 1 cycle start and 1 cycle FIN.

Test Plan:
- Memory-model slave (ack registered on the falling edge when stb&cyc), src=0x010000, dst=0x000010, len=3, words 1/5/239 → writes 0x0001, 0x0005, 0x00EF at 0x000010..12. Single done pulse, error=0, wordsDone=3, busy low after done.
- Same copy with the destination slave inserting one wait state (ack two falling edges after stb) → identical memory contents. No duplicate writes: exactly one write per address, checked by a write counter.
- len=0 → done one cycle after busy, wbCycO never asserted, wordsDone=0.
- Destination address unmapped (ack never returns), TIMEOUT=8 → WR strobe held exactly 8 cycles, then cyc=0, error=1, done pulse, wordsDone=0. The next start with a valid range clears error and completes.
- src=0xFFFFFF, len=2 → reads at 0xFFFFFF then 0x000000, and the copy completes normally.
- rst asserted during the second WR of a len=4 job → next edge: cyc/stb/we/busy/done=0. No done pulse; start afterwards runs a fresh job from its new addresses.

Source files
------------

// File: rtl/wb_copy_master.sv
// Wishbone classic initiator that copies a block of words from one address
// range to another. Each word is read, then written. A one-cycle idle gap
// follows every strobe. Every strobe is guarded by an ack timeout.
module wb_copy_master #(
  parameter int ADDR_W  = 24,
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] srcAdr,
  input  logic [ADDR_W-1:0] dstAdr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [LEN_W-1:0]  wordsDone,
  output logic [ADDR_W-1:0] wbAdrO,
  output logic [DATA_W-1:0] wbDatO,
  input  logic [DATA_W-1:0] wbDatI,
  output logic              wbCycO,
  output logic              wbStbO,
  output logic              wbWeO,
  input  logic              wbAckI
);

  // The strobe counter only has to reach TIMEOUT-1. The abort fires on the
  // last un-acked cycle.
  localparam int               TMO_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RGAP,
    WR,
    WGAP,
    FIN
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   src_q, src_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [DATA_W-1:0]   dato_q, dato_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  // Next-state, datapath updates and bus outputs, decoded from the current state
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    dato_d  = dato_q;
    tmo_d   = tmo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    error_d = error_q;
    wbCycO  = 1'b0;
    wbStbO  = 1'b0;
    wbWeO   = 1'b0;
    wbAdrO  = '0;

    case (state_q)
      IDLE: begin
        // During the done-pulse cycle the FSM is already back in IDLE.
        // Masking start with done_q keeps a request in that cycle from
        // being taken.
        if (start && !done_q) begin
          src_d   = srcAdr;
          dst_d   = dstAdr;
          len_d   = len;
          cnt_d   = '0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          tmo_d   = '0;
          state_d = (len == '0) ? FIN : RD;
        end
      end

      RD: begin
        wbCycO = 1'b1;
        wbStbO = 1'b1;
        wbAdrO = src_q;
        if (wbAckI) begin
          data_d  = wbDatI;
          state_d = RGAP;
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      RGAP: begin
        wbCycO  = 1'b1;
        dato_d  = data_q;
        tmo_d   = '0;
        state_d = WR;
      end

      WR: begin
        wbCycO = 1'b1;
        wbStbO = 1'b1;
        wbWeO  = 1'b1;
        wbAdrO = dst_q;
        if (wbAckI) begin
          cnt_d   = cnt_q + LEN_W'(1);
          src_d   = src_q + ADDR_W'(1);
          dst_d   = dst_q + ADDR_W'(1);
          state_d = WGAP;
        end else if (tmo_q == TMO_LAST) begin
          error_d = 1'b1;
          state_d = FIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      WGAP: begin
        wbCycO  = 1'b1;
        tmo_d   = '0;
        state_d = (cnt_q == len_q) ? FIN : RD;
      end

      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      dato_q  <= '0;
      tmo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      dato_q  <= dato_d;
      tmo_q   <= tmo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign wordsDone = cnt_q;
  assign wbDatO    = dato_q;

endmodule
